distribute_tree_pipe: RTL and testbench



---
 rtl/distribute_tree_pipe.sv | 85 ++++++++
 tb/tb_distribute_tree_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/distribute_tree_pipe.sv
// rtl/distribute_tree_pipe.sv - pipelined binary fan-out tree with per-leaf destination mask
// One word is split down NUM_LEVEL registered levels to NUM_OUTPUT_DATA leaves.
module distribute_tree_pipe #(
    parameter  int NUM_OUTPUT_DATA = 8,
    parameter  int DATA_WIDTH      = 32,
    localparam int NUM_LEVEL       = $clog2(NUM_OUTPUT_DATA)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [DATA_WIDTH-1:0]                 i_data_bus,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_dest_mask,
    input  logic                                  i_en,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic                                  o_busy
);
    localparam int N     = NUM_OUTPUT_DATA;
    localparam int DW    = DATA_WIDTH;
    localparam int L     = NUM_LEVEL;
    localparam int NODES = 2 * N - 2;
    localparam int ML    = (L > 1) ? L - 1 : 1;

    // Nodes are stored flat: level j node k lives at index (2^j - 2) + k.
    logic [NODES-1:0]    node_valid;
    logic [NODES*DW-1:0] node_data;
    // A level's node masks concatenate to a full N-bit vector; slot j-1 holds level j.
    logic [ML*N-1:0]     node_mask;

    logic [NODES-1:0]    par_valid;
    logic [NODES-1:0]    par_sel;
    logic [NODES*DW-1:0] par_data;
    logic [N-1:0]        par_mask;
    logic [N-1:0]        rng;

    always_comb begin
        par_valid = '0;
        par_sel   = '0;
        par_data  = '0;
        par_mask  = '0;
        rng       = '0;
        for (int j = 1; j <= L; j++) begin
            par_mask = (j == 1) ? i_dest_mask : node_mask[((j >= 2) ? (j - 2) : 0)*N +: N];
            for (int k = 0; k < N; k++) begin
                if (k < (1 << j)) begin
                    // Child k at level j covers leaves [k*(N>>j) +: N>>j].
                    rng = ({N{1'b1}} >> (N - (N >> j))) << (k * (N >> j));
                    par_sel[(1 << j) - 2 + k] = |(par_mask & rng);
                    if (j == 1) begin
                        par_valid[k]           = i_valid;
                        par_data[k*DW +: DW]   = i_data_bus;
                    end else begin
                        par_valid[(1 << j) - 2 + k] = node_valid[(1 << (j - 1)) - 2 + (k >> 1)];
                        par_data[((1 << j) - 2 + k)*DW +: DW] =
                            node_data[((1 << (j - 1)) - 2 + (k >> 1))*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            node_valid <= '0;
            node_data  <= '0;
            node_mask  <= '0;
        end else if (i_en) begin
            for (int i = 0; i < NODES; i++) begin
                node_valid[i]         <= par_valid[i] & par_sel[i];
                node_data[i*DW +: DW] <= (par_valid[i] & par_sel[i]) ? par_data[i*DW +: DW] : '0;
            end
            if (L > 1) begin
                node_mask[N-1:0] <= i_dest_mask;
                for (int j = 2; j < L; j++) begin
                    node_mask[(j-1)*N +: N] <= node_mask[(j-2)*N +: N];
                end
            end
        end
    end

    assign o_valid    = node_valid[N-2 +: N];
    assign o_data_bus = node_data[(N-2)*DW +: N*DW];
    assign o_busy     = |node_valid;

endmodule

// File: tb/tb_distribute_tree_pipe.sv
// tb/tb_distribute_tree_pipe.sv - scoreboard bench for distribute_tree_pipe
module tb_distribute_tree_pipe;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef struct {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        int              cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic [DW-1:0]   i_data_bus = '0;
    logic [N-1:0]    i_dest_mask = '0;
    logic            i_en = 1'b1;
    logic [N-1:0]    o_valid;
    logic [N*DW-1:0] o_data_bus;
    logic            o_busy;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   en_cnt = 0;
    int   seen = 0;
    logic upd = 1'b0;

    distribute_tree_pipe #(.NUM_OUTPUT_DATA(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
        .i_dest_mask(i_dest_mask), .i_en(i_en), .o_valid(o_valid),
        .o_data_bus(o_data_bus), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        upd <= i_en && !rst;
        if (i_en && !rst) en_cnt <= en_cnt + 1;
    end

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: consumes one scoreboard entry each time fresh leaf data appears.
    always @(negedge clk) begin
        if (upd && o_valid != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got valid %h data %h expected none", o_valid, o_data_bus);
            end else begin
                exp_t e;
                e = sb.pop_front();
                seen++;
                chk("leaf_valid", {{(N*DW-N){1'b0}}, o_valid}, {{(N*DW-N){1'b0}}, e.v});
                chk("leaf_data", o_data_bus, e.d);
                chk("leaf_latency", (N*DW)'(en_cnt), (N*DW)'(e.cnt));
            end
        end
    end

    task automatic cyc(input logic r, input logic en, input logic v,
                       input logic [DW-1:0] d, input logic [N-1:0] m);
        exp_t e;
        rst = r; i_en = en; i_valid = v; i_data_bus = d; i_dest_mask = m;
        if (!r && en && v && m != '0) begin
            e.v = m;
            e.d = '0;
            for (int k = 0; k < N; k++)
                if (m[k]) e.d[k*DW +: DW] = d;
            e.cnt = en_cnt + LAT;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, {{(N*DW-N){1'b0}}, o_valid}, '0);
        chk({name, "_data"}, o_data_bus, '0);
        chk({name, "_busy"}, {{(N*DW-1){1'b0}}, o_busy}, '0);
    endtask

    initial begin
        // Reset
        cyc(1, 1, 0, '0, '0);
        cyc(1, 1, 0, '0, '0);
        chk_idle("reset");

        // Broadcast: busy for exactly three cycles
        cyc(0, 1, 1, 32'hA5A5A5A5, 8'hFF);
        chk("bcast_busy1", {{(N*DW-1){1'b0}}, o_busy}, 1);
        cyc(0, 1, 0, '0, '0);
        chk("bcast_busy2", {{(N*DW-1){1'b0}}, o_busy}, 1);
        cyc(0, 1, 0, '0, '0);
        chk("bcast_busy3", {{(N*DW-1){1'b0}}, o_busy}, 1);
        chk("bcast_leaves", o_data_bus, {8{32'hA5A5A5A5}});
        cyc(0, 1, 0, '0, '0);
        chk_idle("bcast_drain");

        // Partial mask: leaves 1, 4, 7
        cyc(0, 1, 1, 32'h11, 8'b1001_0010);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, '0);
        chk_idle("partial_drain");

        // Back-to-back stream
        cyc(0, 1, 1, 32'd1, 8'h01);
        cyc(0, 1, 1, 32'd2, 8'h80);
        cyc(0, 1, 1, 32'd3, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, '0);
        chk_idle("stream_drain");

        // Stall with the word at level 2; input offered while stalled must be ignored
        cyc(0, 1, 1, 32'h5A5A0001, 8'h0F);
        cyc(0, 1, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 32'hDEADBEEF, 8'hFF);
            chk("stall_busy", {{(N*DW-1){1'b0}}, o_busy}, 1);
            chk("stall_valid", {{(N*DW-N){1'b0}}, o_valid}, '0);
        end
        cyc(0, 1, 0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, '0, '0);
            chk("stall_hold_valid", {{(N*DW-N){1'b0}}, o_valid}, {{(N*DW-N){1'b0}}, 8'h0F});
            chk("stall_hold_data", o_data_bus, {{4{32'h0}}, {4{32'h5A5A0001}}});
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, '0);
        chk_idle("stall_drain");

        // Zero mask: word dropped
        cyc(0, 1, 1, 32'hFF, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk_idle("zero_mask");
            cyc(0, 1, 0, '0, '0);
        end

        // Reset mid-flight: both in-flight words are discarded
        cyc(0, 1, 1, 32'h00C0FFEE, 8'hFF);
        cyc(0, 1, 1, 32'h0000BEEF, 8'h3C);
        sb.delete();
        cyc(1, 1, 0, '0, '0);
        chk_idle("midreset");
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, '0, '0);
            chk("midreset_busy", {{(N*DW-1){1'b0}}, o_busy}, '0);
        end

        chk("sb_drained", (N*DW)'(sb.size()), '0);
        chk("words_seen", (N*DW)'(seen), (N*DW)'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
